// File: rtl/flash_pkg.sv
// Shared types and constants for the runtime flash read path.
// The transmit-byte helper keeps the command/address framing in one place.
package flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } flash_rd_state_t;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam int         FLASH_ADDR_W   = 24;

    // Byte sent on MOSI for a given position within a READ transaction.
    function automatic logic [7:0] flash_tx_byte(
        input logic [2:0]              idx,
        input logic [7:0]              cmd,
        input logic [FLASH_ADDR_W-1:0] addr
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = cmd;
            3'd1:    b = addr[23:16];
            3'd2:    b = addr[15:8];
            3'd3:    b = addr[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/flash_read_ctrl.sv
// Runtime flash word reader: issues READ + 24-bit address through the byte-level
// spi_engine, gathers four data bytes and returns them as a little-endian word.
module flash_read_ctrl
    import flash_pkg::*;
#(
    parameter logic [7:0] READ_CMD = FLASH_CMD_READ,
    parameter int         CS_GAP   = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [FLASH_ADDR_W-1:0] req_addr_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [31:0]             rsp_data_o,
    output logic                    spi_start_o,
    output logic [7:0]              spi_out_o,
    input  logic [7:0]              spi_in_i,
    input  logic                    spi_done_i,
    input  logic                    spi_busy_i,
    output logic                    flash_csb_o,
    output logic                    busy_o
);

    localparam logic [3:0] GAP_MAX = 4'(CS_GAP);
    localparam logic [FLASH_ADDR_W-1:0] ADDR_ALIGN_MASK = {{(FLASH_ADDR_W-2){1'b1}}, 2'b00};

    flash_rd_state_t         state_q, state_d;
    logic [FLASH_ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]              bcnt_q, bcnt_d;
    logic [31:0]             data_q, data_d;
    logic [7:0]              spi_out_q, spi_out_d;
    logic                    csb_q, csb_d;
    logic [3:0]              gap_q, gap_d;
    logic                    taken_q, taken_d;
    logic                    rsp_hs;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            bcnt_q    <= 3'd0;
            data_q    <= 32'h0;
            spi_out_q <= 8'h00;
            csb_q     <= 1'b1;
            gap_q     <= GAP_MAX;
            taken_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            bcnt_q    <= bcnt_d;
            data_q    <= data_d;
            spi_out_q <= spi_out_d;
            csb_q     <= csb_d;
            gap_q     <= gap_d;
            taken_q   <= taken_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        bcnt_d      = bcnt_q;
        data_d      = data_q;
        spi_out_d   = spi_out_q;
        csb_d       = csb_q;
        gap_d       = gap_q;
        taken_d     = taken_q;
        req_ready_o = 1'b0;
        spi_start_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_hs      = 1'b0;

        // Gap counter tracks CSB-high cycles and saturates; it starts at 1 on the rise.
        if (csb_q && (gap_q < GAP_MAX)) begin
            gap_d = gap_q + 4'd1;
        end

        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                spi_out_d   = 8'h00;
                taken_d     = 1'b0;
                if (req_valid_i) begin
                    addr_d  = req_addr_i & ADDR_ALIGN_MASK;
                    bcnt_d  = 3'd0;
                    csb_d   = 1'b0;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                spi_out_d = flash_tx_byte(bcnt_q, READ_CMD, addr_q);
                state_d   = ST_ISSUE;
            end

            ST_ISSUE: begin
                if (!spi_busy_i) begin
                    spi_start_o = 1'b1;
                    state_d     = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (spi_done_i) begin
                    // Bytes 4..7 are the data phase; first one lands in the low byte.
                    if (bcnt_q[2]) begin
                        case (bcnt_q[1:0])
                            2'd0:    data_d[7:0]   = spi_in_i;
                            2'd1:    data_d[15:8]  = spi_in_i;
                            2'd2:    data_d[23:16] = spi_in_i;
                            default: data_d[31:24] = spi_in_i;
                        endcase
                    end
                    if (bcnt_q == 3'd7) begin
                        csb_d   = 1'b1;
                        gap_d   = 4'd1;
                        state_d = ST_RESP;
                    end else begin
                        bcnt_d    = bcnt_q + 3'd1;
                        spi_out_d = flash_tx_byte(bcnt_q + 3'd1, READ_CMD, addr_q);
                        state_d   = ST_ISSUE;
                    end
                end
            end

            ST_RESP: begin
                rsp_valid_o = !taken_q;
                rsp_hs      = !taken_q && rsp_ready_i;
                if (rsp_hs) begin
                    taken_d = 1'b1;
                end
                // A consumer that answers quickly still has to wait out the CSB gap.
                if ((taken_q || rsp_hs) && (gap_q >= GAP_MAX)) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rsp_data_o  = data_q;
    assign spi_out_o   = spi_out_q;
    assign flash_csb_o = csb_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Bench for flash_read_ctrl: a behavioural spi_engine/flash model feeds the DUT,
// expected words and command frames go into queues that independent monitors drain.
module tb_flash_read_ctrl;
    import flash_pkg::*;

    localparam int CS_GAP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic [23:0] reqAddr = 24'h0;
    logic        rspValid;
    logic        rspReady = 1'b0;
    logic [31:0] rspData;
    logic        spiStart;
    logic [7:0]  spiOut;
    logic [7:0]  engIn = 8'h00;
    logic        engDone = 1'b0;
    logic        engBusy = 1'b0;
    logic        strayDone = 1'b0;
    logic        spiDone;
    logic        csb;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int rspMode = 0;
    int acceptCnt = 0;
    int csbFalls = 0;
    int startCnt = 0;
    int doneCnt = 0;

    logic [31:0] expRspQ[$];
    logic [23:0] expCmdQ[$];
    logic [7:0]  mosiQ[$];
    logic [7:0]  mem[int];

    always #5 clk = ~clk;

    assign spiDone = engDone | strayDone;

    flash_read_ctrl #(.READ_CMD(8'h03), .CS_GAP(CS_GAP)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_valid_i (reqValid),
        .req_ready_o (reqReady),
        .req_addr_i  (reqAddr),
        .rsp_valid_o (rspValid),
        .rsp_ready_i (rspReady),
        .rsp_data_o  (rspData),
        .spi_start_o (spiStart),
        .spi_out_o   (spiOut),
        .spi_in_i    (engIn),
        .spi_done_i  (spiDone),
        .spi_busy_i  (engBusy),
        .flash_csb_o (csb),
        .busy_o      (busy)
    );

    function automatic logic [7:0] memByte(input logic [23:0] a);
        if (mem.exists(int'({8'h00, a}))) return mem[int'({8'h00, a})];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5C;
    endfunction

    // A READ of any address returns the four bytes from its word-aligned base.
    function automatic logic [31:0] modelWord(input logic [23:0] a);
        logic [23:0] base;
        base = a & 24'hFFFFFC;
        return {memByte(base + 24'd3), memByte(base + 24'd2), memByte(base + 24'd1), memByte(base)};
    endfunction

    // Engine model: random transfer latency, random busy tail after each done.
    int         engPhase = 0;
    int         engCnt = 0;
    int         tail;
    int         idx;
    logic [7:0] engByte = 8'h00;

    always @(posedge clk) begin
        engDone <= 1'b0;
        if (reset) begin
            engBusy  <= 1'b0;
            engPhase <= 0;
            engCnt   <= 0;
        end else begin
            if (csb) begin
                doneCnt <= 0;
                mosiQ.delete();
            end
            case (engPhase)
                0: if (spiStart) begin
                    idx = mosiQ.size();
                    if (idx >= 4)
                        engByte <= memByte({mosiQ[1], mosiQ[2], mosiQ[3]} + 24'(idx - 4));
                    else
                        engByte <= 8'hFF;
                    mosiQ.push_back(spiOut);
                    engBusy  <= 1'b1;
                    engCnt   <= $urandom_range(0, 3);
                    engPhase <= 1;
                end
                1: if (engCnt == 0) begin
                    engDone <= 1'b1;
                    engIn   <= engByte;
                    doneCnt <= doneCnt + 1;
                    tail = $urandom_range(0, 2);
                    if (tail == 0) begin
                        engBusy  <= 1'b0;
                        engPhase <= 0;
                    end else begin
                        engCnt   <= tail - 1;
                        engPhase <= 2;
                    end
                end else begin
                    engCnt <= engCnt - 1;
                end
                default: if (engCnt == 0) begin
                    engBusy  <= 1'b0;
                    engPhase <= 0;
                end else begin
                    engCnt <= engCnt - 1;
                end
            endcase
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rspMode == 0) rspReady = 1'b1;
        else if (rspMode == 1) rspReady = 1'($urandom_range(0, 1));
    end

    // Monitor: response scoreboard, command frame check, CSB gap and start protocol.
    logic        prevCsb = 1'b1;
    logic        prevStart = 1'b0;
    int          highCnt = 0;
    bit          havePrev = 1'b0;
    bit          gapExempt = 1'b0;
    bit          abortFlag = 1'b0;
    logic [31:0] monExp;
    logic [23:0] cmdAddr;
    logic [63:0] gotFrame;
    logic [63:0] expFrame;

    always @(negedge clk) begin
        if (!reset) begin
            if (rspValid && rspReady) begin
                checks++;
                if (expRspQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rsp_unexpected: got %h expected no response", rspData);
                end else begin
                    monExp = expRspQ.pop_front();
                    if (rspData !== monExp) begin
                        errors++;
                        $display("[TB] FAIL rsp_data: got %h expected %h", rspData, monExp);
                    end
                end
            end
            if (spiStart) begin
                startCnt++;
                checks++;
                if (engBusy || prevStart || csb) begin
                    errors++;
                    $display("[TB] FAIL start_protocol: busy=%0b prevStart=%0b csb=%0b expected 0 0 0",
                             engBusy, prevStart, csb);
                end
            end
            if (prevCsb && !csb) begin
                csbFalls++;
                if (havePrev && !gapExempt) begin
                    checks++;
                    if (highCnt < CS_GAP) begin
                        errors++;
                        $display("[TB] FAIL csb_gap: got %0d high cycles expected >= %0d", highCnt, CS_GAP);
                    end
                end
                gapExempt = 1'b0;
            end
            if (!prevCsb && csb) begin
                if (abortFlag) begin
                    abortFlag = 1'b0;
                    gapExempt = 1'b1;
                    if (expCmdQ.size() > 0) void'(expCmdQ.pop_front());
                end else begin
                    checks++;
                    gotFrame = 64'h0;
                    for (int i = 0; i < mosiQ.size() && i < 8; i++) gotFrame = {gotFrame[55:0], mosiQ[i]};
                    if (expCmdQ.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL cmd_unexpected: got %h expected no transaction", gotFrame);
                    end else begin
                        cmdAddr  = expCmdQ.pop_front();
                        expFrame = {8'h03, cmdAddr, 32'h0};
                        if (mosiQ.size() != 8 || gotFrame !== expFrame) begin
                            errors++;
                            $display("[TB] FAIL cmd_frame: got %0d bytes %h expected 8 bytes %h",
                                     mosiQ.size(), gotFrame, expFrame);
                        end
                    end
                end
                havePrev = 1'b1;
            end
            highCnt   = csb ? highCnt + 1 : 0;
            prevCsb   = csb;
            prevStart = spiStart;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [23:0] addr);
        int waited;
        waited = 0;
        @(posedge clk);
        #1;
        reqValid = 1'b1;
        reqAddr  = addr;
        forever begin
            @(negedge clk);
            if (reqReady) break;
            waited++;
            if (waited > 3000) begin
                checks++;
                errors++;
                $display("[TB] FAIL req_timeout: got no req_ready expected ready within 3000 cycles");
                reqValid = 1'b0;
                return;
            end
        end
        expRspQ.push_back(modelWord(addr));
        expCmdQ.push_back(addr & 24'hFFFFFC);
        acceptCnt++;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
    endtask

    task automatic waitIdle();
        int waited;
        waited = 0;
        forever begin
            @(negedge clk);
            if (expRspQ.size() == 0 && !busy) break;
            waited++;
            if (waited > 5000) begin
                checks++;
                errors++;
                $display("[TB] FAIL idle_timeout: got %0d pending expected 0", expRspQ.size());
                return;
            end
        end
    endtask

    task automatic waitRspValid();
        int waited;
        waited = 0;
        forever begin
            @(negedge clk);
            if (rspValid) break;
            waited++;
            if (waited > 2000) begin
                checks++;
                errors++;
                $display("[TB] FAIL rsp_timeout: got rsp_valid=0 expected 1");
                return;
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] expW;
        int sc;
        int waited;

        mem[32'h104] = 8'h11;
        mem[32'h105] = 8'h22;
        mem[32'h106] = 8'h33;
        mem[32'h107] = 8'h44;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_csb", 32'(csb), 32'd1);
        checkOutput("rst_start", 32'(spiStart), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_spi_out", 32'(spiOut), 32'd0);
        checkOutput("rst_rsp_data", rspData, 32'd0);
        checkOutput("rst_req_ready", 32'(reqReady), 32'd1);

        rspMode = 0;
        checkOutput("basic_model", modelWord(24'h000104), 32'h44332211);
        applyStimulus(24'h000104);
        waitIdle();
        applyStimulus(24'h00010B);
        waitIdle();

        rspMode  = 2;
        rspReady = 1'b0;
        applyStimulus(24'h000310);
        expW = modelWord(24'h000310);
        waitRspValid();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("bp_valid", 32'(rspValid), 32'd1);
            checkOutput("bp_data", rspData, expW);
            checkOutput("bp_req_ready", 32'(reqReady), 32'd0);
        end
        @(posedge clk);
        #1;
        rspReady = 1'b1;
        @(posedge clk);
        #1;
        rspReady = 1'b0;
        @(negedge clk);
        checkOutput("bp_ready_after", 32'(reqReady), 32'd1);
        waitIdle();

        rspMode = 0;
        for (int i = 0; i < 4; i++) applyStimulus(24'($urandom_range(0, 24'hFFFFFF)));
        waitIdle();

        rspMode = 1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(24'($urandom_range(0, 24'hFFFFFF)));
            repeat ($urandom_range(0, 5)) @(posedge clk);
        end
        waitIdle();

        rspMode = 0;
        applyStimulus(24'h000300);
        waited = 0;
        forever begin
            @(negedge clk);
            if (doneCnt == 5) break;
            waited++;
            if (waited > 2000) begin
                checks++;
                errors++;
                $display("[TB] FAIL byte5_timeout: got %0d done pulses expected 5", doneCnt);
                break;
            end
        end
        reset     = 1'b1;
        abortFlag = 1'b1;
        if (expRspQ.size() > 0) void'(expRspQ.pop_back());
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_csb", 32'(csb), 32'd1);
        checkOutput("abort_rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("abort_req_ready", 32'(reqReady), 32'd1);
        acceptCnt--;
        csbFalls--;
        applyStimulus(24'h000200);
        waitIdle();

        @(negedge clk);
        sc = startCnt;
        @(posedge clk);
        #1;
        strayDone = 1'b1;
        @(posedge clk);
        #1;
        strayDone = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("stray_req_ready", 32'(reqReady), 32'd1);
        checkOutput("stray_busy", 32'(busy), 32'd0);
        checkOutput("stray_starts", 32'(startCnt), 32'(sc));

        rspMode  = 2;
        rspReady = 1'b0;
        applyStimulus(24'h000420);
        waitRspValid();
        sc = startCnt;
        @(posedge clk);
        #1;
        reqValid  = 1'b1;
        reqAddr   = 24'h000800;
        strayDone = 1'b1;
        @(posedge clk);
        #1;
        strayDone = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("hold_rsp_valid", 32'(rspValid), 32'd1);
            checkOutput("hold_req_ready", 32'(reqReady), 32'd0);
        end
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        rspReady = 1'b1;
        @(posedge clk);
        #1;
        rspReady = 1'b0;
        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("hold_starts", 32'(startCnt), 32'(sc));
        checkOutput("txn_count", 32'(csbFalls), 32'(acceptCnt));
        checkOutput("queue_empty", 32'(expRspQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
